// File: rtl/tank_pkg.sv
// Shared types and grid constants for tank movement.
// Directions, move FSM states and footprint half-size.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    QUERY,
    COOLDOWN
  } move_state_t;

  localparam int DEF_GAME_W = 64;
  localparam int DEF_GAME_H = 48;
  localparam int TANK_HALF  = 2;

endpackage

// File: rtl/tank_cooldown_timer.sv
// Movement rate-limit timer: load on accept, count to zero.
// Zero flag releases the move FSM back to IDLE.
module tank_cooldown_timer #(
  parameter int MOVE_PERIOD = 2_500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_zero
);

  localparam int TW = $clog2(MOVE_PERIOD + 1);
  // Accept edge plus the zero-detect cycle make up the rest of the period.
  localparam logic [TW-1:0] LOAD_VAL = TW'(MOVE_PERIOD - 2);

  logic [TW-1:0] cnt_q, cnt_d;

  // Reload on accept, otherwise saturate down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/tank_move_ctrl.sv
// Tank position/facing owner with map-checked, rate-limited steps.
// Display outputs are shadowed and refreshed only at frame start.
module tank_move_ctrl
  import tank_pkg::*;
#(
  parameter int         GAME_W      = DEF_GAME_W,
  parameter int         GAME_H      = DEF_GAME_H,
  parameter int         MOVE_PERIOD = 2_500_000,
  parameter logic [5:0] INIT_X      = 6'd4,
  parameter logic [5:0] INIT_Y      = 6'd4,
  parameter logic [1:0] INIT_DIR    = 2'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd_dir,
  output logic       o_cmd_ready,
  output logic       o_query_valid,
  output logic [5:0] o_query_x,
  output logic [5:0] o_query_y,
  input  logic       i_query_done,
  input  logic       i_query_blocked,
  input  logic       i_frame_start,
  output logic [5:0] o_tank_x,
  output logic [5:0] o_tank_y,
  output logic [1:0] o_tank_dir
);

  localparam int LO   = TANK_HALF;
  localparam int X_HI = GAME_W - 1 - TANK_HALF;
  localparam int Y_HI = GAME_H - 1 - TANK_HALF;

  move_state_t state_q, state_d;
  logic [5:0]  pos_x_q, pos_x_d;
  logic [5:0]  pos_y_q, pos_y_d;
  dir_t        dir_q, dir_d;
  logic [5:0]  qx_q, qx_d;
  logic [5:0]  qy_q, qy_d;
  logic [5:0]  disp_x_q, disp_y_q;
  logic [1:0]  disp_dir_q;
  logic [5:0]  tx, ty;
  logic        t_ok;
  logic        accept;
  logic        load;
  logic        t_zero;

  assign o_cmd_ready   = (state_q == IDLE) && i_enable;
  assign accept        = i_cmd_valid && o_cmd_ready;
  assign o_query_valid = (state_q == QUERY);
  assign o_query_x     = qx_q;
  assign o_query_y     = qy_q;
  assign o_tank_x      = disp_x_q;
  assign o_tank_y      = disp_y_q;
  assign o_tank_dir    = disp_dir_q;

  tank_cooldown_timer #(
    .MOVE_PERIOD(MOVE_PERIOD)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_load(load),
    .o_zero(t_zero)
  );

  // Candidate cell; range test uses the current position so no wrap occurs.
  always_comb begin
    tx   = pos_x_q;
    ty   = pos_y_q;
    t_ok = 1'b0;
    unique case (dir_t'(i_cmd_dir))
      DIR_UP: begin
        ty   = pos_y_q - 6'd1;
        t_ok = int'(pos_y_q) > LO;
      end
      DIR_DOWN: begin
        ty   = pos_y_q + 6'd1;
        t_ok = int'(pos_y_q) < Y_HI;
      end
      DIR_LEFT: begin
        tx   = pos_x_q - 6'd1;
        t_ok = int'(pos_x_q) > LO;
      end
      DIR_RIGHT: begin
        tx   = pos_x_q + 6'd1;
        t_ok = int'(pos_x_q) < X_HI;
      end
    endcase
  end

  // Move FSM next state: accept, query the map, then cool down.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load  = 1'b1;
          dir_d = dir_t'(i_cmd_dir);
          if (t_ok) begin
            qx_d    = tx;
            qy_d    = ty;
            state_d = QUERY;
          end else begin
            state_d = COOLDOWN;
          end
        end
      end
      QUERY: begin
        if (i_query_done) begin
          if (!i_query_blocked) begin
            pos_x_d = qx_q;
            pos_y_d = qy_q;
          end
          state_d = t_zero ? IDLE : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (t_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pos_x_q <= INIT_X;
      pos_y_q <= INIT_Y;
      dir_q   <= dir_t'(INIT_DIR);
      qx_q    <= INIT_X;
      qy_q    <= INIT_Y;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
    end
  end

  // Frame-stable display shadow; a coincident step shows next frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      disp_x_q   <= INIT_X;
      disp_y_q   <= INIT_Y;
      disp_dir_q <= INIT_DIR;
    end else if (i_frame_start) begin
      disp_x_q   <= pos_x_q;
      disp_y_q   <= pos_y_q;
      disp_dir_q <= dir_q;
    end
  end

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Directed bench for tank_move_ctrl with MOVE_PERIOD=8.
// Vector table for single steps plus hand sequences for timing.
module tb_tank_move_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cv, qd, qb, fs;
  logic [1:0] cd;
  logic       rdy, qv;
  logic [5:0] qx, qy, tx, ty;
  logic [1:0] tdir;

  int errors = 0;
  int checks = 0;

  logic       q;
  logic [5:0] ox, oy;
  int         acc, last;
  logic [31:0] rmask;

  typedef struct {
    logic [1:0] dir;
    logic       blk;
    logic       exp_q;
    logic [5:0] eqx;
    logic [5:0] eqy;
    logic [5:0] ex;
    logic [5:0] ey;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  tank_move_ctrl #(
    .MOVE_PERIOD(8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_cmd_valid    (cv),
    .i_cmd_dir      (cd),
    .o_cmd_ready    (rdy),
    .o_query_valid  (qv),
    .o_query_x      (qx),
    .o_query_y      (qy),
    .i_query_done   (qd),
    .i_query_blocked(qb),
    .i_frame_start  (fs),
    .o_tank_x       (tx),
    .o_tank_y       (ty),
    .o_tank_dir     (tdir)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, rdy}, 32'd1);
  endtask

  task automatic move(input logic [1:0] d, input logic blk, input int lat,
                      output logic oq, output logic [5:0] x, output logic [5:0] y);
    wait_ready();
    cv = 1'b1;
    cd = d;
    tick();
    cv = 1'b0;
    oq = qv;
    x  = qx;
    y  = qy;
    if (oq) begin
      repeat (lat - 1) tick();
      qd = 1'b1;
      qb = blk;
      tick();
      qd = 1'b0;
      qb = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 1'b1, 1'b1, 6'd6, 6'd3, 6'd6, 6'd4};
    tbl[1] = '{2'd2, 1'b0, 1'b1, 6'd5, 6'd4, 6'd5, 6'd4};
    tbl[2] = '{2'd1, 1'b0, 1'b1, 6'd5, 6'd5, 6'd5, 6'd5};
    tbl[3] = '{2'd0, 1'b0, 1'b1, 6'd5, 6'd4, 6'd5, 6'd4};
    tbl[4] = '{2'd0, 1'b0, 1'b1, 6'd5, 6'd3, 6'd5, 6'd3};
    tbl[5] = '{2'd0, 1'b0, 1'b1, 6'd5, 6'd2, 6'd5, 6'd2};
    tbl[6] = '{2'd0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd5, 6'd2};
    tbl[7] = '{2'd3, 1'b1, 1'b1, 6'd6, 6'd2, 6'd5, 6'd2};
    tbl[8] = '{2'd1, 1'b0, 1'b1, 6'd5, 6'd3, 6'd5, 6'd3};
    tbl[9] = '{2'd2, 1'b0, 1'b1, 6'd4, 6'd3, 6'd4, 6'd3};

    rst = 1'b1; en = 1'b1; cv = 1'b0; cd = 2'd0;
    qd = 1'b0; qb = 1'b0; fs = 1'b0;
    tick();
    tick();
    check("rst_x", tx, 4);
    check("rst_y", ty, 4);
    check("rst_dir", tdir, 0);
    check("rst_qv", qv, 0);
    rst = 1'b0;
    tick();
    check("rst_ready", rdy, 1);

    // Free step right, answered three cycles after accept.
    wait_ready();
    check("t2_ready_c0", rdy, 1);
    cv = 1'b1; cd = 2'd3;
    tick();
    cv = 1'b0;
    check("t2_qv", qv, 1);
    check("t2_qx", qx, 5);
    check("t2_qy", qy, 4);
    check("t2_ready_c1", rdy, 0);
    tick();
    tick();
    check("t2_qx_held", qx, 5);
    qd = 1'b1; qb = 1'b0;
    tick();
    qd = 1'b0;
    check("t2_qv_drop", qv, 0);
    check("t2_shadow_old", tx, 4);
    repeat (3) tick();
    check("t2_ready_c7", rdy, 0);
    tick();
    check("t2_ready_c8", rdy, 1);
    frame();
    check("t2_x", tx, 5);
    check("t2_y", ty, 4);
    check("t2_dir", tdir, 3);

    // Frame start coincides with the position update.
    wait_ready();
    cv = 1'b1; cd = 2'd3;
    tick();
    cv = 1'b0;
    tick();
    tick();
    qd = 1'b1; fs = 1'b1;
    tick();
    qd = 1'b0; fs = 1'b0;
    check("t6_old_x", tx, 5);
    frame();
    check("t6_new_x", tx, 6);

    // Single-step vectors from (6,4).
    for (int i = 0; i < 10; i++) begin
      move(tbl[i].dir, tbl[i].blk, 1 + (i % 4), q, ox, oy);
      check($sformatf("v%0d_query", i), q, tbl[i].exp_q);
      if (tbl[i].exp_q) begin
        check($sformatf("v%0d_qx", i), ox, tbl[i].eqx);
        check($sformatf("v%0d_qy", i), oy, tbl[i].eqy);
      end
      frame();
      check($sformatf("v%0d_x", i), tx, tbl[i].ex);
      check($sformatf("v%0d_y", i), ty, tbl[i].ey);
      check($sformatf("v%0d_dir", i), tdir, tbl[i].dir);
    end

    // Asynchronous reset in the middle of a query.
    wait_ready();
    cv = 1'b1; cd = 2'd0;
    tick();
    cv = 1'b0;
    check("r_qv_before", qv, 1);
    #2 rst = 1'b1;
    #1;
    check("r_qv_now", qv, 0);
    check("r_x_now", tx, 4);
    check("r_y_now", ty, 4);
    check("r_dir_now", tdir, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qd = 1'b1;
    tick();
    qd = 1'b0;
    check("r_late_done_qv", qv, 0);
    frame();
    check("r_late_x", tx, 4);
    check("r_late_y", ty, 4);
    check("r_ready", rdy, 1);

    // Walk to the left edge at (2,10).
    move(2'd2, 1'b0, 2, q, ox, oy);
    move(2'd2, 1'b0, 2, q, ox, oy);
    repeat (6) move(2'd1, 1'b0, 2, q, ox, oy);
    move(2'd2, 1'b0, 2, q, ox, oy);
    check("edge_l_query", q, 0);
    frame();
    check("edge_l_x", tx, 2);
    check("edge_l_y", ty, 10);
    check("edge_l_dir", tdir, 2);

    // Walk to the right edge at (61,10).
    repeat (59) move(2'd3, 1'b0, 1, q, ox, oy);
    move(2'd3, 1'b0, 1, q, ox, oy);
    check("edge_r_query", q, 0);
    frame();
    check("edge_r_x", tx, 61);
    check("edge_r_dir", tdir, 3);

    // Enable low blocks acceptance.
    wait_ready();
    en = 1'b0;
    #1;
    check("en_ready", rdy, 0);
    cv = 1'b1; cd = 2'd2;
    repeat (3) tick();
    check("en_qv", qv, 0);
    cv = 1'b0;
    en = 1'b1;
    tick();
    frame();
    check("en_x", tx, 61);
    check("en_dir", tdir, 3);

    // Commands every cycle: one accepted per period.
    wait_ready();
    cv = 1'b1; cd = 2'd2;
    acc = 0; last = -100; rmask = '0;
    for (int i = 0; i < 20; i++) begin
      if (rdy) begin
        acc++;
        last = i;
        rmask[i] = 1'b1;
      end
      qd = (qv && (i - last) == 3);
      tick();
    end
    cv = 1'b0;
    qd = 1'b0;
    check("b2b_accepts", acc, 3);
    check("b2b_ready_mask", rmask, 32'h0001_0101);
    frame();
    check("b2b_x", tx, 58);
    check("b2b_dir", tdir, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
